// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter sharing one single-port memory between an
//             I-cache (refill only) and a D-cache (refill or writeback),
//             transferring one BURST-word line per grant.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int BURST = 4
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        I_REQ,
    input  logic [11:0] I_ADDR,
    output logic        I_GNT,
    output logic        I_RVALID,
    output logic        I_DONE,
    output logic [31:0] I_RDATA,

    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [11:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    output logic        D_GNT,
    output logic        D_RVALID,
    output logic        D_DONE,
    output logic        D_WREADY,
    output logic [31:0] D_RDATA,

    output logic        M_CSN,
    output logic        M_WEN,
    output logic [11:0] M_ADDR,
    output logic [31:0] M_DOUT,
    output logic [3:0]  M_BE,
    input  logic [31:0] M_DI
);

    localparam int CW = $clog2(BURST);

    localparam logic [1:0]    c_idle     = 2'd0;
    localparam logic [1:0]    c_rd_burst = 2'd1;
    localparam logic [1:0]    c_rd_drain = 2'd2;
    localparam logic [1:0]    c_wr_burst = 2'd3;

    localparam logic [CW-1:0] c_last_beat = CW'(BURST - 1);
    localparam logic [11:0]   c_line_mask = ~12'(BURST - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [11:0]   r_base;
    logic          r_owner_d;   // 1: D-cache owns the current burst
    logic          r_last_d;    // 1: most recent grant went to D

    logic          w_any_req;
    logic          w_pick_d;
    logic [11:0]   w_req_addr;
    logic          w_in_burst;
    logic          w_first;
    logic          w_rd_valid;

    // D wins a contention unless it was the last one served
    assign w_any_req  = I_REQ | D_REQ;
    assign w_pick_d   = D_REQ & (~I_REQ | ~r_last_d);
    assign w_req_addr = w_pick_d ? D_ADDR : I_ADDR;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= c_idle;
            r_cnt     <= '0;
            r_base    <= '0;
            r_owner_d <= 1'b0;
            r_last_d  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_cnt <= '0;
                    if (w_any_req) begin
                        r_owner_d <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        r_base    <= w_req_addr & c_line_mask;
                        r_state   <= (w_pick_d && D_WE) ? c_wr_burst : c_rd_burst;
                    end
                end
                c_rd_burst: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == c_last_beat) begin
                        r_state <= c_rd_drain;
                    end
                end
                c_rd_drain: begin
                    r_state <= c_idle;
                end
                c_wr_burst: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == c_last_beat) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign w_in_burst = (r_state == c_rd_burst) || (r_state == c_wr_burst);
    assign w_first    = w_in_burst && (r_cnt == '0);
    // One-cycle memory latency: word k appears on M_DI in burst cycle k+1
    assign w_rd_valid = ((r_state == c_rd_burst) && (r_cnt != '0)) ||
                        (r_state == c_rd_drain);

    always_comb begin
        I_GNT    = w_first & ~r_owner_d;
        D_GNT    = w_first &  r_owner_d;
        I_RVALID = w_rd_valid & ~r_owner_d;
        D_RVALID = w_rd_valid &  r_owner_d;
        I_DONE   = (r_state == c_rd_drain) & ~r_owner_d;
        D_DONE   = ((r_state == c_rd_drain) & r_owner_d) ||
                   ((r_state == c_wr_burst) && (r_cnt == c_last_beat));
        D_WREADY = (r_state == c_wr_burst);
        I_RDATA  = I_RVALID ? M_DI : 32'h0;
        D_RDATA  = D_RVALID ? M_DI : 32'h0;

        M_CSN    = ~w_in_burst;
        M_WEN    = (r_state != c_wr_burst);
        M_BE     = w_in_burst ? 4'hF : 4'h0;
        M_ADDR   = w_in_burst ? (r_base | {{(12 - CW){1'b0}}, r_cnt}) : 12'h000;
        M_DOUT   = (r_state == c_wr_burst) ? D_WDATA : 32'h0;
    end

endmodule
`default_nettype wire
